// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//
// Hazard and stall controller for the 5-stage MIPS pipeline. It drives the
// enable, flush and bubble controls of the PC, IF/ID, ID/EX and EX/MEM
// registers.
//
//   - A load-use hazard costs one stall cycle. PC and IF/ID hold while ID/EX
//     takes a bubble.
//   - A redirect resolved in EX (taken branch, jump or jr) flushes IF/ID and
//     bubbles ID/EX for BRANCH_PENALTY cycles.
//   - A data-memory wait freezes every pipeline register.
//   - A watchdog counts consecutive frozen cycles. At MEM_TIMEOUT it parks the
//     block in HALT, and only reset leaves HALT.
//
// Handshake: mem_req/mem_ready form a valid/ready pair for the MEM stage. The
// access completes in the cycle where both are 1. The pipe is frozen in every
// cycle where mem_req=1 and mem_ready=0. mem_ready is ignored while mem_req=0.
// ex_redirect is a level held by its source: it is accepted in the first
// non-frozen cycle in which it is seen.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   id_valid              ID stage holds a real instruction
//   id_rs, id_rt          ID source registers
//   id_uses_rt            ID instruction reads rt
//   ex_ld, ex_ld_dst      EX instruction is a load, and its destination
//   ex_redirect           branch taken / jump / jr resolved in EX
//   mem_req, mem_ready    MEM stage access request / memory completion
//   pc_en                 PC update enable
//   ifid_en, ifid_flush   IF/ID load enable, IF/ID loads a NOP
//   idex_en, idex_bubble  ID/EX load enable, ID/EX loads zero control fields
//   exmem_en              EX/MEM and MEM/WB load enable
//   mem_timeout           sticky watchdog error
//   stall_cnt             saturating count of cycles with pc_en=0
//   redirect_cnt          saturating count of accepted redirects
// -----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int unsigned BRANCH_PENALTY = 1,
    parameter int unsigned MEM_TIMEOUT    = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic        ex_ld,
    input  logic [4:0]  ex_ld_dst,
    input  logic        ex_redirect,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        ifid_flush,
    output logic        idex_en,
    output logic        idex_bubble,
    output logic        exmem_en,
    output logic        mem_timeout,
    output logic [15:0] stall_cnt,
    output logic [15:0] redirect_cnt
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        HALT  = 2'd2
    } state_t;

    localparam logic [2:0]  FLUSH_INIT = 3'(BRANCH_PENALTY - 1);
    localparam logic [15:0] WAIT_LAST  = 16'(MEM_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [2:0]  flush_left_q, flush_left_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic [15:0] stall_cnt_q, redirect_cnt_q;
    logic        mem_timeout_q;

    logic        freeze;
    logic        lu_hit;
    logic        timeout_set;
    logic        redirect_acc;

    // Control values before the reset override.
    logic        pc_c, ifid_en_c, ifid_flush_c, idex_en_c, idex_bubble_c, exmem_c;

    // The register at index 0 never carries a dependency, so a load to it
    // cannot cause a hazard.
    assign freeze = mem_req & ~mem_ready;
    assign lu_hit = id_valid & ex_ld & (ex_ld_dst != 5'd0) &
                    ((id_rs == ex_ld_dst) | (id_uses_rt & (id_rt == ex_ld_dst)));

    // Next state and control outputs. Priority: HALT > freeze > redirect > load-use.
    always_comb begin
        state_d       = state_q;
        flush_left_d  = flush_left_q;
        wait_cnt_d    = wait_cnt_q;
        timeout_set   = 1'b0;
        redirect_acc  = 1'b0;
        pc_c          = 1'b1;
        ifid_en_c     = 1'b1;
        ifid_flush_c  = 1'b0;
        idex_en_c     = 1'b1;
        idex_bubble_c = 1'b0;
        exmem_c       = 1'b1;

        case (state_q)
            HALT: begin
                pc_c      = 1'b0;
                ifid_en_c = 1'b0;
                idex_en_c = 1'b0;
                exmem_c   = 1'b0;
            end
            default: begin
                if (freeze) begin
                    // Everything holds, including flush_left. Any redirect or
                    // hazard is re-presented by its source after the wait.
                    pc_c      = 1'b0;
                    ifid_en_c = 1'b0;
                    idex_en_c = 1'b0;
                    exmem_c   = 1'b0;
                    if (wait_cnt_q == WAIT_LAST) begin
                        state_d     = HALT;
                        timeout_set = 1'b1;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 16'd1;
                    end
                end else begin
                    wait_cnt_d = 16'd0;
                    if (ex_redirect) begin
                        ifid_flush_c  = 1'b1;
                        idex_bubble_c = 1'b1;
                        redirect_acc  = 1'b1;
                        // A new redirect inside FLUSH restarts the penalty window.
                        if (BRANCH_PENALTY > 1) begin
                            state_d      = FLUSH;
                            flush_left_d = FLUSH_INIT;
                        end else begin
                            state_d      = RUN;
                            flush_left_d = 3'd0;
                        end
                    end else if (state_q == FLUSH) begin
                        ifid_flush_c  = 1'b1;
                        idex_bubble_c = 1'b1;
                        flush_left_d  = flush_left_q - 3'd1;
                        if (flush_left_q == 3'd1) begin
                            state_d = RUN;
                        end
                    end else if (lu_hit) begin
                        // The bubble clears ex_ld next cycle, so this stall
                        // lasts exactly one cycle.
                        pc_c          = 1'b0;
                        ifid_en_c     = 1'b0;
                        idex_bubble_c = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= RUN;
            flush_left_q   <= 3'd0;
            wait_cnt_q     <= 16'd0;
            stall_cnt_q    <= 16'd0;
            redirect_cnt_q <= 16'd0;
            mem_timeout_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            flush_left_q <= flush_left_d;
            wait_cnt_q   <= wait_cnt_d;
            if (timeout_set) begin
                mem_timeout_q <= 1'b1;
            end
            if (!pc_c && state_q != HALT && stall_cnt_q != 16'hFFFF) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
            if (redirect_acc && redirect_cnt_q != 16'hFFFF) begin
                redirect_cnt_q <= redirect_cnt_q + 16'd1;
            end
        end
    end

    // While reset is held, every register is disabled and ID/EX is bubbled,
    // so the pipe comes out of reset with empty control fields.
    assign pc_en        = rst_n & pc_c;
    assign ifid_en      = rst_n & ifid_en_c;
    assign ifid_flush   = rst_n & ifid_flush_c;
    assign idex_en      = rst_n & idex_en_c;
    assign idex_bubble  = ~rst_n | idex_bubble_c;
    assign exmem_en     = rst_n & exmem_c;
    assign mem_timeout  = mem_timeout_q;
    assign stall_cnt    = stall_cnt_q;
    assign redirect_cnt = redirect_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//
// Bench for hazard_ctrl with BRANCH_PENALTY=3 and MEM_TIMEOUT=8. A
// behavioural model tracks these values as plain integers:
//   - the flush cycles still owed
//   - the consecutive frozen cycles
//   - the halted flag
//   - the two counters
// From them it predicts every control output for each cycle.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

    localparam int BP = 3;
    localparam int MT = 8;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        id_valid = 1'b0;
    logic [4:0]  id_rs = '0;
    logic [4:0]  id_rt = '0;
    logic        id_uses_rt = 1'b0;
    logic        ex_ld = 1'b0;
    logic [4:0]  ex_ld_dst = '0;
    logic        ex_redirect = 1'b0;
    logic        mem_req = 1'b0;
    logic        mem_ready = 1'b0;
    logic        pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, mem_timeout;
    logic [15:0] stall_cnt, redirect_cnt;

    hazard_ctrl #(.BRANCH_PENALTY(BP), .MEM_TIMEOUT(MT)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_ld(ex_ld), .ex_ld_dst(ex_ld_dst), .ex_redirect(ex_redirect),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
        .idex_en(idex_en), .idex_bubble(idex_bubble), .exmem_en(exmem_en),
        .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .redirect_cnt(redirect_cnt)
    );

    // scoreboard
    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // reference model
    bit m_halt;
    bit m_to;
    int m_flush_rem;   // flush cycles still owed after the current one
    int m_wait;        // consecutive frozen cycles seen so far
    int m_stall;
    int m_redir;

    function automatic void model_clear();
        m_halt = 0; m_to = 0; m_flush_rem = 0; m_wait = 0; m_stall = 0; m_redir = 0;
    endfunction

    function automatic bit model_lu();
        return id_valid && ex_ld && ex_ld_dst != 0 &&
               (id_rs == ex_ld_dst || (id_uses_rt && id_rt == ex_ld_dst));
    endfunction

    // {pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, mem_timeout}
    function automatic logic [6:0] model_out();
        bit frz;
        frz = mem_req && !mem_ready;
        if (!rst_n)                           return 7'b0000100;
        if (m_halt)                           return {6'b000000, m_to};
        if (frz)                              return {6'b000000, m_to};
        if (ex_redirect || m_flush_rem > 0)   return {6'b111111, m_to};
        if (model_lu())                       return {6'b000111, m_to};
        return {6'b110101, m_to};
    endfunction

    function automatic void model_edge(input logic [6:0] o);
        bit frz;
        frz = mem_req && !mem_ready;
        if (m_halt) return;
        if (o[6] == 1'b0 && m_stall < 65535) m_stall++;
        if (frz) begin
            m_wait++;
            if (m_wait >= MT) begin
                m_halt = 1;
                m_to = 1;
            end
        end else begin
            m_wait = 0;
            if (ex_redirect) begin
                if (m_redir < 65535) m_redir++;
                m_flush_rem = BP - 1;
            end else if (m_flush_rem > 0) begin
                m_flush_rem--;
            end
        end
    endfunction

    // driver tasks
    task automatic check_outputs();
        logic [6:0] o;
        o = model_out();
        exp_q.push_back({25'd0, o});
        check("ctrl", {25'd0, pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, mem_timeout},
              exp_q.pop_front());
        check("stall_cnt", {16'd0, stall_cnt}, m_stall);
        check("redirect_cnt", {16'd0, redirect_cnt}, m_redir);
    endtask

    // Called at posedge+1. Inputs are applied, the outputs are checked
    // mid-cycle, and the model steps on the next posedge.
    task automatic step(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urt, input logic ld, input logic [4:0] dst,
                        input logic rdr, input logic req, input logic rdy);
        logic [6:0] o;
        id_valid = v; id_rs = rs; id_rt = rt; id_uses_rt = urt;
        ex_ld = ld; ex_ld_dst = dst; ex_redirect = rdr;
        mem_req = req; mem_ready = rdy;
        #1;
        check_outputs();
        o = model_out();
        @(posedge clk);
        model_edge(o);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Asserts reset mid-cycle, so the outputs and counters must respond
    // without waiting for a clock edge.
    task automatic do_reset();
        rst_n = 1'b0;
        model_clear();
        #1;
        check_outputs();
        @(posedge clk);
        #1;
        check_outputs();
        rst_n = 1'b1;
    endtask

    initial begin
        int burst;
        logic req, rdy;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // load-use: one stall, then idle
        step(1, 5, 0, 0, 1, 5, 0, 0, 0);
        idle();
        check("lu_stall_cnt", {16'd0, stall_cnt}, 32'd1);
        // load to r0 never stalls
        step(1, 0, 0, 0, 1, 0, 0, 0, 0);
        // rt match only counts when rt is read
        step(1, 1, 7, 0, 1, 7, 0, 0, 0);
        step(1, 1, 7, 1, 1, 7, 0, 0, 0);
        // no valid instruction in ID means no stall
        step(0, 9, 9, 1, 1, 9, 0, 0, 0);
        // mem_ready without mem_req, and a completed access: no freeze
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 1, 1);

        // redirect pulse: 3 flush cycles, then RUN
        step(0, 0, 0, 0, 0, 0, 1, 0, 0);
        idle(); idle();
        idle();
        check("redir_cnt_one", {16'd0, redirect_cnt}, 32'd1);

        // freeze for 4 cycles on the second flush cycle
        step(0, 0, 0, 0, 0, 0, 1, 0, 0);
        repeat (4) step(0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(); idle();
        idle();

        // priority: freeze wins, then redirect beats load-use
        step(1, 5, 0, 0, 1, 5, 1, 1, 0);
        step(1, 5, 0, 0, 1, 5, 1, 1, 1);
        step(1, 5, 0, 0, 1, 5, 0, 0, 0);
        step(1, 5, 0, 0, 1, 5, 0, 0, 0);
        step(1, 5, 0, 0, 1, 5, 0, 0, 0);

        // watchdog: 8 frozen cycles lead to HALT
        repeat (MT) step(0, 0, 0, 0, 0, 0, 0, 1, 0);
        check("halt_timeout", {31'd0, mem_timeout}, 32'd1);
        repeat (3) step(1, 5, 0, 0, 1, 5, 1, 1, 1);
        do_reset();

        // 7 frozen cycles, then a release: no HALT
        repeat (MT - 1) step(0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle();
        repeat (MT - 1) step(0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle();

        // reset in the middle of FLUSH, after 10 stalls
        do_reset();
        repeat (10) begin
            step(1, 3, 0, 0, 1, 3, 0, 0, 0);
            idle();
        end
        check("stall_ten", {16'd0, stall_cnt}, 32'd10);
        step(0, 0, 0, 0, 0, 0, 1, 0, 0);
        idle();
        do_reset();

        // randomized traffic with occasional long memory waits
        burst = 0;
        for (int i = 0; i < 2000; i++) begin
            if ((m_halt && $urandom_range(0, 3) == 0) || $urandom_range(0, 249) == 0) begin
                do_reset();
            end
            if (burst == 0 && $urandom_range(0, 39) == 0) burst = $urandom_range(1, 10);
            if (burst > 0) begin
                req = 1'b1; rdy = 1'b0; burst--;
            end else begin
                req = ($urandom_range(0, 2) == 0);
                rdy = ($urandom_range(0, 1) == 1);
            end
            step(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 3)),
                 ($urandom_range(0, 5) == 0), req, rdy);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the 5-stage MIPS core. It drives the enable, flush and bubble controls of the PC, IF/ID, ID/EX and EX/MEM registers. It resolves load-use hazards with a single-cycle stall, squashes wrong-path instructions after a branch, jump or jr resolves in EX, and freezes the whole pipe while data memory is not ready. A memory-wait watchdog moves the block into a terminal HALT state if memory stays not-ready for too long.

## Interface
Parameters:
- BRANCH_PENALTY, 1: total flush cycles per redirect; legal range 1..7.
- MEM_TIMEOUT, 255: consecutive frozen cycles that trigger HALT; legal range 1..65535.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- id_valid  in  1  ID stage holds a real instruction
- id_rs  in  5  ID source register rs
- id_rt  in  5  ID source register rt
- id_uses_rt  in  1  ID instruction reads rt
- ex_ld  in  1  EX instruction is a load
- ex_ld_dst  in  5  EX load destination register
- ex_redirect  in  1  branch taken, jump or jr resolved in EX this cycle
- mem_req  in  1  MEM stage accessing data memory
- mem_ready  in  1  data memory completes this cycle
- pc_en  out  1  PC update enable
- ifid_en  out  1  IF/ID load enable
- ifid_flush  out  1  IF/ID loads a NOP
- idex_en  out  1  ID/EX load enable
- idex_bubble  out  1  ID/EX loads all-zero control fields
- exmem_en  out  1  EX/MEM and MEM/WB load enable
- mem_timeout  out  1  sticky watchdog error
- stall_cnt  out  16  saturating count of cycles with pc_en=0
- redirect_cnt  out  16  saturating count of accepted redirects

## Operation
- Internal signals:
  - freeze = mem_req & ~mem_ready.
  - lu_hit = id_valid & ex_ld & (ex_ld_dst!=0) & (id_rs==ex_ld_dst | (id_uses_rt & id_rt==ex_ld_dst)).
- State register, 2 bits: RUN=0, FLUSH=1, HALT=2. Penalty counter flush_left is 3 bits.
- All outputs are combinational from state and inputs. Priority: HALT > freeze > redirect > load-use.
- HALT:
  - All enables 0, ifid_flush=0, idex_bubble=0.
  - Counters hold.
  - Exit only through reset.
- freeze (in RUN or FLUSH):
  - pc_en, ifid_en, idex_en and exmem_en all 0; ifid_flush=0, idex_bubble=0.
  - ex_redirect and lu_hit are ignored; the source reasserts them after the freeze ends.
  - State and flush_left hold.
- Redirect accepted (not frozen, ex_redirect=1, in RUN or FLUSH):
  - pc_en=1, ifid_en=1, ifid_flush=1, idex_en=1, idex_bubble=1, exmem_en=1.
  - redirect_cnt increments.
  - If BRANCH_PENALTY>1: next state FLUSH, flush_left = BRANCH_PENALTY-1. Otherwise next state RUN.
- FLUSH with no freeze and no redirect:
  - Same outputs as an accepted redirect.
  - flush_left decrements; the block returns to RUN when flush_left reaches 0 (the last FLUSH cycle is the one with flush_left==1).
  - lu_hit is ignored.
- RUN with lu_hit (no freeze, no redirect):
  - pc_en=0, ifid_en=0, idex_en=1, idex_bubble=1, exmem_en=1, ifid_flush=0.
  - State stays RUN. The stall lasts exactly one cycle because the bubble clears ex_ld.
- RUN idle: all enables 1, ifid_flush=0, idex_bubble=0.
- Watchdog:
  - wait_cnt (16 bit) increments on each frozen cycle and clears on any non-frozen cycle.
  - When a frozen cycle is sampled with wait_cnt==MEM_TIMEOUT-1: next state HALT and mem_timeout<=1.
- stall_cnt increments on each posedge where pc_en=0 and state!=HALT. It saturates at 16'hFFFF.
- redirect_cnt saturates at 16'hFFFF.

## Timing
- Control outputs have zero-cycle latency: they are combinational from inputs within the same cycle. The pipeline registers act on them at the next posedge.
- While rst_n=0:
  - State is RUN; flush_left, wait_cnt, stall_cnt and redirect_cnt are 0; mem_timeout=0.
  - Outputs are forced: all enables 0, ifid_flush=0, idex_bubble=1.
- Reset release: normal RUN behaviour from the first posedge with rst_n=1.
- Reset asserted mid-FLUSH or in HALT: the block returns to RUN immediately (asynchronous) and all counters clear.
- Load-use: one cycle of pc_en=0 per hazard. A back-to-back load followed by its dependent instruction costs exactly one bubble.
- Redirect arriving in the same cycle as freeze is not accepted until the first non-frozen cycle. There is no lost or duplicated redirect as long as the source holds it.
- mem_ready=1 with mem_req=1 is not a freeze. mem_ready with mem_req=0 has no effect.

## Test plan
- Load-use: ex_ld=1, ex_ld_dst=5, id_rs=5, id_valid=1 -> one cycle with pc_en=0, ifid_en=0, idex_bubble=1; the next cycle is idle RUN; stall_cnt=1. Repeat with ex_ld_dst=0 -> no stall.
- Redirect with BRANCH_PENALTY=3: ex_redirect pulse -> ifid_flush=1 and idex_bubble=1 for exactly 3 consecutive cycles, then RUN; redirect_cnt=1.
- Freeze during FLUSH: mem_req=1, mem_ready=0 for 4 cycles on the second flush cycle -> all enables 0 for those 4 cycles, then the remaining 2 flush cycles; stall_cnt=4.
- Priority: ex_redirect, lu_hit and freeze together -> freeze outputs. After mem_ready, with redirect still held -> redirect outputs, not load-use.
- Watchdog with MEM_TIMEOUT=8: freeze held 8 cycles -> HALT and mem_timeout=1 after the 8th posedge; mem_ready=1 afterwards leaves everything stuck at 0; pulsing rst_n low restores RUN with mem_timeout=0.
- Reset mid-operation: assert rst_n=0 in FLUSH with stall_cnt=10 -> outputs forced to reset values immediately, counters read 0.
